// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU transaction front end.
// Optional build macro: ALU_TXN_CHECK_EN (enables the internal result model).
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;

    // One queued ALU command.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } cmd_t;

    // Sequencer states; the encoding is visible on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Reference result the ALU should return for a command.
    // Unsupported opcodes are expected to come back as zero.
    function automatic logic [DATA_W-1:0] alu_model(input cmd_t c);
        logic [DATA_W-1:0] r;
        r = '0;
        case (c.op)
            OP_ADD:  r = c.a + c.b;
            OP_SUB:  r = c.a - c.b;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO for alu_txn_ctrl.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    cmd_t        mem [DEPTH];

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer update; a push while full is dropped even if a pop happens in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage write; contents need no reset because empty masks stale entries.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/alu_txn_ctrl.sv
// Transaction front end for the 8-bit combinational ALU.
// Commands are buffered in a FIFO, driven onto the ALU, held for
// SETTLE_CYCLES, then the sampled result is returned on the response port.
// Optional build macro: ALU_TXN_CHECK_EN compares the ALU against an
// internal model and flags disagreement on rsp_mismatch.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// A producer holds valid and its payload stable until the transfer; ready
// may be asserted independently of valid. cmd_ready depends only on the
// FIFO full flag, and rsp_* never change while rsp_valid && !rsp_ready.
module alu_txn_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [OP_W-1:0]   rsp_op,
    output logic              rsp_err,
    output logic              rsp_mismatch,
    output logic              busy,
    output state_t            dbg_state
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;
    cmd_t             fifo_in;
    cmd_t             fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;

    assign fifo_in   = '{a: cmd_a, b: cmd_b, op: cmd_op};
    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    // Only IDLE pops, so a response hand-off never overlaps the next pop.
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    assign busy      = (state != ST_IDLE) || !fifo_empty;
    assign dbg_state = state;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef ALU_TXN_CHECK_EN
    cmd_t alu_cur;
    assign alu_cur = '{a: alu_a, b: alu_b, op: alu_op};
`else
    assign rsp_mismatch = 1'b0;
`endif

    // Sequencer: load ALU inputs, wait the settle window, capture and hand off the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_op     <= '0;
            rsp_err    <= 1'b0;
`ifdef ALU_TXN_CHECK_EN
            rsp_mismatch <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        alu_a      <= fifo_head.a;
                        alu_b      <= fifo_head.b;
                        alu_op     <= fifo_head.op;
                        settle_cnt <= CNT_INIT;
                        state      <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (settle_cnt == '0) begin
                        rsp_result <= alu_result;
                        rsp_op     <= alu_op;
                        rsp_err    <= (alu_op > OP_SUB);
                        rsp_valid  <= 1'b1;
`ifdef ALU_TXN_CHECK_EN
                        rsp_mismatch <= (alu_result != alu_model(alu_cur));
`endif
                        state      <= ST_RESP;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_txn_ctrl.sv
// Directed bench for alu_txn_ctrl: a behavioural ALU sits on the alu_* port,
// the driver pushes hand-computed expectations into exp_q, and a monitor
// pops and compares each response as it is handed off.
module tb_alu_txn_ctrl;
    import alu_pkg::*;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 2;
`ifdef ALU_TXN_CHECK_EN
    localparam logic CHECK_ON = 1'b1;
`else
    localparam logic CHECK_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a = '0;
    logic [DATA_W-1:0] cmd_b = '0;
    logic [OP_W-1:0]   cmd_op = '0;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_result;
    logic [OP_W-1:0]   rsp_op;
    logic              rsp_err;
    logic              rsp_mismatch;
    logic              busy;
    state_t            dbg_state;
    logic              alu_corrupt = 1'b0;

    alu_txn_ctrl #(
        .DEPTH         (DEPTH),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_op       (cmd_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_op       (rsp_op),
        .rsp_err      (rsp_err),
        .rsp_mismatch (rsp_mismatch),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // Behavioural ALU; alu_corrupt forces a wrong answer for the model check.
    always_comb begin
        alu_result = 8'h00;
        if (alu_corrupt) begin
            alu_result = 8'hFF;
        end else if (alu_op == 3'b000) begin
            alu_result = alu_a + alu_b;
        end else if (alu_op == 3'b001) begin
            alu_result = alu_a - alu_b;
        end
    end

    // ---------------- scoreboard ----------------
    // Entry layout: {mismatch, op, err, result}
    logic [12:0] exp_q[$];
    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    logic [12:0] mon_snap;
    logic        mon_stalled = 1'b0;

    // Monitor: compare on hand-off, and check the payload holds while stalled.
    initial begin
        logic [12:0] got;
        logic [12:0] exp;
        forever begin
            @(negedge clk);
            got = {rsp_mismatch, rsp_op, rsp_err, rsp_result};
            if (!rst_n) begin
                mon_stalled = 1'b0;
            end else begin
                if (mon_stalled) begin
                    check("stall_hold", {rsp_valid, got}, {1'b1, mon_snap});
                end
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", rsp_valid, 1'b0);
                    end else if (rsp_ready) begin
                        exp = exp_q.pop_front();
                        check("rsp", got, exp);
                    end
                end
                mon_stalled = rsp_valid && !rsp_ready;
                mon_snap    = got;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [7:0] exp_r, input logic exp_err, input logic exp_mm);
        int waited;
        waited = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        while (!cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL cmd_accept_timeout: cmd_ready stayed 0, required 1");
        end else begin
            exp_q.push_back({exp_mm, op, exp_err, exp_r});
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_queue", exp_q.size(), 0);
        check("drain_busy", busy, 1'b0);
    endtask

    task automatic check_reset_vals(input string name);
        check(name,
              {cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_op,
               rsp_err, rsp_mismatch, busy, dbg_state},
              {1'b1, 34'd0, ST_IDLE});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset_values");
        rst_n = 1'b1;

        // Single ADD and its latency: valid after accept edge + 1 + SETTLE edges.
        send(8'd5, 8'd3, 3'b000, 8'd8, 1'b0, 1'b0);
        check("busy_after_accept", busy, 1'b1);
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, SETTLE + 1);
        wait_drain();

        // Arithmetic wrap, unsupported opcodes, streaming with rsp_ready high.
        send(8'd2,   8'd9,   3'b001, 8'hF9, 1'b0, 1'b0);
        send(8'd200, 8'd100, 3'b000, 8'd44,  1'b0, 1'b0);
        send(8'd7,   8'd7,   3'b101, 8'h00, 1'b1, 1'b0);
        send(8'h80,  8'h01,  3'b001, 8'h7F, 1'b0, 1'b0);
        send(8'hFF,  8'h01,  3'b111, 8'h00, 1'b1, 1'b0);
        wait_drain();

        // Backpressure: one in flight plus DEPTH queued fills the FIFO.
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        send(8'd10,  8'd20, 3'b000, 8'd30,  1'b0, 1'b0);
        send(8'd50,  8'd60, 3'b001, 8'hF6, 1'b0, 1'b0);
        send(8'd255, 8'd1,  3'b000, 8'h00, 1'b0, 1'b0);
        send(8'd3,   8'd4,  3'b010, 8'h00, 1'b1, 1'b0);
        send(8'd100, 8'd1,  3'b001, 8'd99,  1'b0, 1'b0);
        @(negedge clk);
        check("cmd_ready_full", cmd_ready, 1'b0);
        // Offer an extra command while full; it must not be taken.
        cmd_valid = 1'b1;
        cmd_a     = 8'h55;
        cmd_b     = 8'h11;
        cmd_op    = 3'b001;
        repeat (3) @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("cmd_ready_still_full", cmd_ready, 1'b0);
        check("stalled_valid", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        wait_drain();

        // Reset while DRIVE holds a command: nothing may come out afterwards.
        send(8'd9, 8'd9, 3'b000, 8'd18, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("in_drive_before_reset", dbg_state, ST_DRIVE);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 check_reset_vals("reset_mid_drive");
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1 check("busy_post_reset", busy, 1'b0);

        // Faulty ALU result is passed through; flagged only when the model is built.
        @(posedge clk);
        #1 alu_corrupt = 1'b1;
        send(8'd1, 8'd1, 3'b000, 8'hFF, 1'b0, CHECK_ON);
        wait_drain();
        alu_corrupt = 1'b0;
        send(8'd1, 8'd1, 3'b000, 8'd2, 1'b0, 1'b0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Watchdog so the run can never hang.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
